// File: rtl/core_pkg.sv
// Shared definitions for the core control path: control-operation encodings,
// sequencer state enum and the fixed index of the CONTROL stage.
package core_pkg;

  typedef enum logic [1:0] {
    CTRL_TRAP      = 2'b00,
    CTRL_INTERRUPT = 2'b01,
    CTRL_NORMAL    = 2'b11
  } ctrl_op_e;

  typedef enum logic [1:0] {
    S_CONTROL = 2'b00,
    S_RUN     = 2'b01,
    S_HALT    = 2'b10
  } seq_state_e;

  localparam int STAGE_CONTROL = 0;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder: valid when any request bit is set,
// idx is the position of the lowest set bit (zero when none).
module prio_enc #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    valid = |req;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks a one-hot stage vector from CONTROL
// through the non-skipped RUN stages, picks TRAP/INTERRUPT/NORMAL at each
// instruction boundary, aborts on faults or a stalled stage, halts on a
// fault during a trap handler and counts retired NORMAL instructions.
module stage_sequencer
  import core_pkg::*;
#(
  parameter int NUM_STAGES    = 7,
  parameter int NUM_FAULT_SRC = 4,
  parameter int NUM_IRQ       = 2,
  parameter int FAULT_W       = 3,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_STAGES-1:0]    stage_done,
  input  logic [NUM_STAGES-1:0]    skip_mask,
  input  logic [NUM_FAULT_SRC-1:0] fault_in,
  input  logic [NUM_IRQ-1:0]       irq_pending,
  input  logic [NUM_IRQ-1:0]       irq_enable,
  output logic [NUM_STAGES-1:0]    stage_active,
  output logic [1:0]               control_op,
  output logic [FAULT_W-1:0]       fault_num,
  output logic                     halted,
  output logic [CNT_W-1:0]         instret
);

  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  ctrl_op_e           op_q, op_d;
  logic [FAULT_W-1:0] fault_num_q, fault_num_d;
  logic               fault_pending_q, fault_pending_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               fault_vld;
  logic [FAULT_W-1:0] fault_idx;
  logic               irq_vld;
  logic [FAULT_W-1:0] irq_idx;
  logic [NUM_STAGES-1:0] next_cand;
  logic               next_vld;
  logic [STAGE_W-1:0] next_idx;
  logic               done_cur;
  logic               wd_expire;

  prio_enc #(.WIDTH(NUM_FAULT_SRC), .IDX_W(FAULT_W)) u_fault_enc (
    .req   (fault_in),
    .valid (fault_vld),
    .idx   (fault_idx)
  );

  prio_enc #(.WIDTH(NUM_IRQ), .IDX_W(FAULT_W)) u_irq_enc (
    .req   (irq_pending & irq_enable),
    .valid (irq_vld),
    .idx   (irq_idx)
  );

  prio_enc #(.WIDTH(NUM_STAGES), .IDX_W(STAGE_W)) u_next_enc (
    .req   (next_cand),
    .valid (next_vld),
    .idx   (next_idx)
  );

  // Candidate successor stages: strictly above the current one and not skipped.
  always_comb begin
    next_cand = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      next_cand[j] = (STAGE_W'(j) > stage_q) && !skip_mask[j];
    end
  end

  // Watchdog fires on the TIMEOUT-th cycle a stage sits without its done.
  always_comb begin
    done_cur  = stage_done[stage_q];
    wd_expire = (TIMEOUT != 0) && !done_cur && (stall_q == STALL_W'(TIMEOUT - 1));
  end

  // Next-state logic: operation select in CONTROL, advance/abort in RUN.
  always_comb begin
    state_d         = state_q;
    stage_d         = stage_q;
    op_d            = op_q;
    fault_num_d     = fault_num_q;
    fault_pending_d = fault_pending_q;
    stall_d         = stall_q;
    instret_d       = instret_q;

    unique case (state_q)
      S_CONTROL: begin
        state_d = S_RUN;
        stage_d = STAGE_W'(1);
        stall_d = '0;
        if (fault_pending_q) begin
          op_d            = CTRL_TRAP;
          fault_pending_d = 1'b0;
        end else if (irq_vld) begin
          op_d        = CTRL_INTERRUPT;
          fault_num_d = irq_idx;
        end else begin
          op_d = CTRL_NORMAL;
        end
      end

      S_RUN: begin
        if (fault_vld || wd_expire) begin
          fault_num_d = fault_vld ? fault_idx : FAULT_W'(NUM_FAULT_SRC);
          stall_d     = '0;
          stage_d     = STAGE_W'(STAGE_CONTROL);
          if (op_q == CTRL_TRAP) begin
            state_d = S_HALT;
          end else begin
            state_d         = S_CONTROL;
            fault_pending_d = 1'b1;
          end
        end else if (done_cur) begin
          stall_d = '0;
          if (next_vld) begin
            stage_d = next_idx;
          end else begin
            state_d = S_CONTROL;
            stage_d = STAGE_W'(STAGE_CONTROL);
            if (op_q == CTRL_NORMAL) instret_d = instret_q + CNT_W'(1);
          end
        end else if (TIMEOUT != 0) begin
          stall_d = stall_q + STALL_W'(1);
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // State registers; async reset forces the CONTROL entry point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_CONTROL;
      stage_q         <= STAGE_W'(STAGE_CONTROL);
      op_q            <= CTRL_NORMAL;
      fault_num_q     <= '0;
      fault_pending_q <= 1'b0;
      stall_q         <= '0;
      instret_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q         <= state_d;
      stage_q         <= stage_d;
      op_q            <= op_d;
      fault_num_q     <= fault_num_d;
      fault_pending_q <= fault_pending_d;
      stall_q         <= stall_d;
      instret_q       <= instret_d;
    end
  end

  // Outputs decode straight from registered state.
  always_comb begin
    stage_active = (state_q == S_HALT) ? '0 : (NUM_STAGES'(1) << stage_q);
    control_op   = op_q;
    fault_num    = fault_num_q;
    halted       = (state_q == S_HALT);
    instret      = instret_q;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a cycle-level behavioural model
// compared against the DUT on every falling edge, plus directed scenarios
// with hand-computed literal expectations.
module tb_stage_sequencer;

  localparam int N    = 7;
  localparam int NF   = 4;
  localparam int NI   = 2;
  localparam int FW   = 3;
  localparam int TO   = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  stage_done = '0;
  logic [N-1:0]  skip_mask = '0;
  logic [NF-1:0] fault_in = '0;
  logic [NI-1:0] irq_pending = '0;
  logic [NI-1:0] irq_enable = '0;
  logic [N-1:0]  stage_active;
  logic [1:0]    control_op;
  logic [FW-1:0] fault_num;
  logic          halted;
  logic [CW-1:0] instret;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  stage_sequencer #(
    .NUM_STAGES(N), .NUM_FAULT_SRC(NF), .NUM_IRQ(NI),
    .FAULT_W(FW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stage_done   (stage_done),
    .skip_mask    (skip_mask),
    .fault_in     (fault_in),
    .irq_pending  (irq_pending),
    .irq_enable   (irq_enable),
    .stage_active (stage_active),
    .control_op   (control_op),
    .fault_num    (fault_num),
    .halted       (halted),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_stage: 0 = CONTROL, 1..N-1 = running stage, -1 = halted.
  int m_stage, m_op, m_fnum, m_instret, m_dwell, m_k, m_fidx, m_nxt;
  bit m_pend, m_expired;

  function automatic int lowest_set(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stage = 0; m_op = 3; m_fnum = 0; m_pend = 0; m_instret = 0; m_dwell = 1;
    end else if (m_stage == 0) begin
      if (m_pend) begin
        m_op = 0; m_pend = 0;
      end else if ((irq_pending & irq_enable) != 0) begin
        m_op = 1; m_fnum = lowest_set(32'(irq_pending & irq_enable), NI);
      end else begin
        m_op = 3;
      end
      m_stage = 1; m_dwell = 1;
    end else if (m_stage > 0) begin
      m_k       = m_stage;
      m_fidx    = lowest_set(32'(fault_in), NF);
      m_expired = (TO > 0) && !stage_done[m_k] && (m_dwell >= TO);
      if (m_fidx >= 0 || m_expired) begin
        m_fnum = (m_fidx >= 0) ? m_fidx : NF;
        if (m_op == 0) m_stage = -1;
        else begin m_stage = 0; m_pend = 1; end
      end else if (stage_done[m_k]) begin
        m_nxt = 0;
        for (int j = N - 1; j > m_k; j--) if (!skip_mask[j]) m_nxt = j;
        if (m_nxt == 0 && m_op == 3) m_instret = (m_instret + 1) % (1 << CW);
        m_stage = m_nxt; m_dwell = 1;
      end else begin
        m_dwell++;
      end
    end
  end

  function automatic logic [N-1:0] model_sa();
    logic [N-1:0] one = 1;
    return (m_stage < 0) ? '0 : (one << m_stage);
  endfunction

  // Continuous model-vs-DUT comparison on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_stage_active", 64'(stage_active), 64'(model_sa()));
      check("cmp_control_op",   64'(control_op),   64'(m_op));
      check("cmp_fault_num",    64'(fault_num),    64'(m_fnum));
      check("cmp_halted",       64'(halted),       64'(m_stage < 0));
      check("cmp_instret",      64'(instret),      64'(m_instret));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Assert reset between edges and confirm outputs snap to reset values.
  task automatic assert_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_rst_sa"},      64'(stage_active), 64'h01);
    check({tag, "_rst_op"},      64'(control_op),   64'h3);
    check({tag, "_rst_fnum"},    64'(fault_num),    64'h0);
    check({tag, "_rst_halted"},  64'(halted),       64'h0);
    check({tag, "_rst_instret"}, 64'(instret),      64'h0);
  endtask

  task automatic start(input string tag, input logic [N-1:0] done, input logic [N-1:0] skip,
                       input logic [NI-1:0] irqp, input logic [NI-1:0] irqe);
    assert_reset(tag);
    stage_done = done; skip_mask = skip; fault_in = '0;
    irq_pending = irqp; irq_enable = irqe;
    step(); step();
    reset = 1'b1;
  endtask

  logic [N-1:0] exp1 [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01};
  logic [N-1:0] exp2 [6] = '{7'h01, 7'h02, 7'h04, 7'h10, 7'h40, 7'h01};

  initial begin
    // Initial reset to bring DUT and model out of X.
    step(); step();
    cmp_en = 1'b1;

    // T1: all stages, done tied high.
    start("t1", '1, '0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      check($sformatf("t1_sa%0d", i), 64'(stage_active), 64'(exp1[i]));
    end
    check("t1_instret", 64'(instret), 64'h1);

    // T2: stages 3 and 5 skipped.
    start("t2", '1, 7'b0101000, '0, '0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      check($sformatf("t2_sa%0d", i), 64'(stage_active), 64'(exp2[i]));
    end

    // T3: fault in stage 2 coinciding with its done.
    start("t3", '1, '0, '0, '0);
    step(); step();
    check("t3_in_stage2", 64'(stage_active), 64'h04);
    fault_in = 4'b0110;
    step();
    fault_in = '0;
    check("t3_ctrl_sa", 64'(stage_active), 64'h01);
    step();
    check("t3_trap_op",   64'(control_op), 64'h0);
    check("t3_trap_fnum", 64'(fault_num),  64'h1);
    repeat (6) step();
    check("t3_back_ctrl", 64'(stage_active), 64'h01);
    check("t3_instret",   64'(instret),      64'h0);

    // T4: interrupt at first CONTROL, then fault beats pending irq.
    start("t4", '1, '0, 2'b10, 2'b11);
    step();
    check("t4_irq_op",   64'(control_op), 64'h1);
    check("t4_irq_fnum", 64'(fault_num),  64'h1);
    step();
    fault_in = 4'b0001;
    step();
    fault_in = '0;
    step();
    check("t4_trap_op",   64'(control_op), 64'h0);
    check("t4_trap_fnum", 64'(fault_num),  64'h0);
    irq_pending = '0;
    repeat (6) step();
    check("t4_instret", 64'(instret), 64'h0);

    // T5: watchdog on stage 3, then double fault to HALT.
    start("t5", 7'b1110111, '0, '0, '0);
    repeat (10) step();
    check("t5_still_s3", 64'(stage_active), 64'h08);
    step();
    check("t5_wd_sa",   64'(stage_active), 64'h01);
    check("t5_wd_fnum", 64'(fault_num),    64'h4);
    step();
    check("t5_trap_op", 64'(control_op), 64'h0);
    step();
    fault_in = 4'b0100;
    step();
    fault_in = '0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_halted%0d", i), 64'(halted),       64'h1);
      check($sformatf("t5_sa_off%0d", i), 64'(stage_active), 64'h0);
      step();
    end

    // T6: minimum-length instructions and counter wrap, then mid-run reset.
    start("t6", '1, 7'b1111110, '0, '0);
    repeat (32) step();
    check("t6_wrap16", 64'(instret), 64'h0);
    repeat (2) step();
    check("t6_wrap17", 64'(instret), 64'h1);
    skip_mask = '0;
    repeat (4) step();
    check("t6_in_s4", 64'(stage_active), 64'h10);
    assert_reset("t6mid");
    step(); step();
    reset = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
